// File: rtl/y86_fetch_decode_execute_if.sv
// Bus bundle for the Y86 fetch/decode/execute block.
//   master : drives program counter, instruction-memory byte writes and the two
//            writeback ports; observes every fetch/decode/execute result.
//   slave  : the datapath side of the same signals.
interface y86_fetch_decode_execute_if;
    logic [63:0] p_ctr;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [3:0]  wb_dst_e;
    logic [63:0] wb_val_e;
    logic [3:0]  wb_dst_m;
    logic [63:0] wb_val_m;

    logic [3:0]  in_code;
    logic [3:0]  in_fun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] val_c;
    logic [63:0] val_p;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_e;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic        flag_halt;
    logic        in_error;
    logic        bad_mem;

    modport master (
        output p_ctr, imem_we, imem_waddr, imem_wdata,
               wb_dst_e, wb_val_e, wb_dst_m, wb_val_m,
        input  in_code, in_fun, ra, rb, val_c, val_p, val_a, val_b, val_e,
               cnd, zf, sf, of, flag_halt, in_error, bad_mem
    );

    modport slave (
        input  p_ctr, imem_we, imem_waddr, imem_wdata,
               wb_dst_e, wb_val_e, wb_dst_m, wb_val_m,
        output in_code, in_fun, ra, rb, val_c, val_p, val_a, val_b, val_e,
               cnd, zf, sf, of, flag_halt, in_error, bad_mem
    );
endinterface

// File: rtl/y86_fetch_decode_execute.sv
// Y86-64 fetch, decode and execute stages around a byte-wide instruction
// memory, a 15-entry register file and the condition-code register.
// Everything from p_ctr to val_e/cnd is combinational; only the memory, the
// register file and the CC register are clocked.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : p_ctr, imem byte write port, E/M writeback ports in;
//                  decoded fields, operands, ALU result, CC and status out
module y86_fetch_decode_execute #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    y86_fetch_decode_execute_if.slave    bus
);
    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_RRMOV = 4'h2, I_IRMOV = 4'h3,
                           I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7,
                           I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    localparam logic [3:0] R_NONE = 4'hF, R_RSP = 4'h4;

    logic [7:0]  imem_q [IMEM_BYTES];
    logic [63:0] regs_q [0:14];
    logic [63:0] regs_d [0:14];
    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;

    // Out-of-range writes are dropped rather than aliased onto low addresses.
    always_ff @(posedge clock) begin
        if (bus.imem_we && (bus.imem_waddr < 64'(IMEM_BYTES)))
            imem_q[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end

    // ---------------- fetch ----------------
    logic [7:0] fbyte [10];
    for (genvar i = 0; i < 10; i++) begin : g_fetch
        logic [63:0] a;
        assign a        = bus.p_ctr + 64'(i);
        assign fbyte[i] = (a < 64'(IMEM_BYTES)) ? imem_q[a[AW-1:0]] : 8'h00;
    end

    logic [3:0]  icode, ifun;
    logic [3:0]  len;
    logic        need_regids, valc_off1, valc_off2;
    logic [63:0] val_c;
    logic [64:0] last_addr;
    logic        bad_mem, in_error;

    assign icode = fbyte[0][7:4];
    assign ifun  = fbyte[0][3:0];

    always_comb begin
        len         = 4'd1;
        need_regids = 1'b0;
        valc_off1   = 1'b0;
        valc_off2   = 1'b0;
        case (icode)
            I_RRMOV, I_OPQ, I_PUSH, I_POP: begin len = 4'd2;  need_regids = 1'b1; end
            I_JXX, I_CALL:                 begin len = 4'd9;  valc_off1 = 1'b1; end
            I_IRMOV, I_RMMOV, I_MRMOV:     begin len = 4'd10; need_regids = 1'b1; valc_off2 = 1'b1; end
            default:                       len = 4'd1;
        endcase
    end

    always_comb begin
        val_c = 64'd0;
        if (valc_off1)
            val_c = {fbyte[8], fbyte[7], fbyte[6], fbyte[5], fbyte[4], fbyte[3], fbyte[2], fbyte[1]};
        else if (valc_off2)
            val_c = {fbyte[9], fbyte[8], fbyte[7], fbyte[6], fbyte[5], fbyte[4], fbyte[3], fbyte[2]};
    end

    // 65-bit so a p_ctr near the top of the address space cannot wrap into range.
    assign last_addr = {1'b0, bus.p_ctr} + 65'(len) - 65'd1;
    assign bad_mem   = (last_addr >= 65'(IMEM_BYTES));

    always_comb begin
        case (icode)
            I_OPQ:          in_error = (ifun > 4'd3);
            I_RRMOV, I_JXX: in_error = (ifun > 4'd6);
            4'hC, 4'hD, 4'hE, 4'hF: in_error = 1'b1;
            default:        in_error = (ifun != 4'd0);
        endcase
    end

    // ---------------- decode ----------------
    logic [3:0]  ra, rb, src_a, src_b;
    logic [63:0] val_a, val_b;

    assign ra = need_regids ? fbyte[1][7:4] : R_NONE;
    assign rb = need_regids ? fbyte[1][3:0] : R_NONE;

    always_comb begin
        case (icode)
            I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = ra;
            I_RET, I_POP:                    src_a = R_RSP;
            default:                         src_a = R_NONE;
        endcase
        case (icode)
            I_RMMOV, I_MRMOV, I_OPQ:         src_b = rb;
            I_CALL, I_RET, I_PUSH, I_POP:    src_b = R_RSP;
            default:                         src_b = R_NONE;
        endcase
    end

    assign val_a = (src_a == R_NONE) ? 64'd0 : regs_q[src_a];
    assign val_b = (src_b == R_NONE) ? 64'd0 : regs_q[src_b];

    // ---------------- execute ----------------
    logic [63:0] alu_add, alu_sub, val_e;
    logic        alu_of;

    assign alu_add = val_b + val_a;
    assign alu_sub = val_b - val_a;

    always_comb begin
        val_e  = 64'd0;
        alu_of = 1'b0;
        case (icode)
            I_RRMOV:         val_e = val_a;
            I_IRMOV:         val_e = val_c;
            I_RMMOV, I_MRMOV: val_e = val_b + val_c;
            I_CALL, I_PUSH:  val_e = val_b - 64'd8;
            I_RET, I_POP:    val_e = val_b + 64'd8;
            I_OPQ: begin
                case (ifun)
                    4'd0: begin
                        val_e  = alu_add;
                        alu_of = (val_a[63] == val_b[63]) && (alu_add[63] != val_b[63]);
                    end
                    4'd1: begin
                        val_e  = alu_sub;
                        alu_of = (val_a[63] != val_b[63]) && (alu_sub[63] != val_b[63]);
                    end
                    4'd2:    val_e = val_b & val_a;
                    4'd3:    val_e = val_b ^ val_a;
                    default: val_e = 64'd0;
                endcase
            end
            default:         val_e = 64'd0;
        endcase
    end

    logic cnd;
    always_comb begin
        cnd = 1'b0;
        if (icode == I_RRMOV || icode == I_JXX) begin
            case (ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = (sf_q ^ of_q) | zf_q;
                4'd2:    cnd = sf_q ^ of_q;
                4'd3:    cnd = zf_q;
                4'd4:    cnd = ~zf_q;
                4'd5:    cnd = ~(sf_q ^ of_q);
                4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    // ---------------- state update ----------------
    always_comb begin
        zf_d = zf_q;
        sf_d = sf_q;
        of_d = of_q;
        if (icode == I_OPQ && !in_error && !bad_mem) begin
            zf_d = (val_e == 64'd0);
            sf_d = val_e[63];
            of_d = alu_of;
        end
    end

    // M port applied after E port so it wins on a shared destination.
    always_comb begin
        for (int i = 0; i < 15; i++) regs_d[i] = regs_q[i];
        if (bus.wb_dst_e != R_NONE) regs_d[bus.wb_dst_e] = bus.wb_val_e;
        if (bus.wb_dst_m != R_NONE) regs_d[bus.wb_dst_m] = bus.wb_val_m;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= 64'd0;
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign bus.in_code   = icode;
    assign bus.in_fun    = ifun;
    assign bus.ra        = ra;
    assign bus.rb        = rb;
    assign bus.val_c     = val_c;
    assign bus.val_p     = bus.p_ctr + 64'(len);
    assign bus.val_a     = val_a;
    assign bus.val_b     = val_b;
    assign bus.val_e     = val_e;
    assign bus.cnd       = cnd;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.of        = of_q;
    assign bus.flag_halt = (icode == I_HALT) && !bad_mem;
    assign bus.in_error  = in_error;
    assign bus.bad_mem   = bad_mem;
endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Directed bench for y86_fetch_decode_execute: small hand-assembled programs,
// expected values worked out by hand from the Y86-64 instruction semantics.
module tb_y86_fetch_decode_execute;
    logic clock;
    logic reset;
    int   tests;
    int   fails;

    y86_fetch_decode_execute_if bus();

    y86_fetch_decode_execute #(.IMEM_BYTES(1024)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Writes n bytes starting at base; byte k is v[79-8k -: 8].
    task automatic load(input logic [63:0] base, input int n, input logic [79:0] v);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            bus.imem_we    = 1'b1;
            bus.imem_waddr = base + 64'(k);
            bus.imem_wdata = v[79-8*k -: 8];
        end
        @(negedge clock);
        bus.imem_we = 1'b0;
    endtask

    task automatic set_regs(input logic [3:0] de, input logic [63:0] ve,
                            input logic [3:0] dm, input logic [63:0] vm);
        @(negedge clock);
        bus.wb_dst_e = de; bus.wb_val_e = ve;
        bus.wb_dst_m = dm; bus.wb_val_m = vm;
        @(negedge clock);
        bus.wb_dst_e = 4'hF; bus.wb_dst_m = 4'hF;
    endtask

    task automatic test_reset;
        // Program loads overlap reset: memory writes must still land.
        load(64'd0, 10, 80'h30F20A00000000000000);
        load(64'd100, 2, {16'h201F, 64'h0});
        @(negedge clock);
        reset = 1'b0;
        bus.p_ctr = 64'd100;
        #1;
        tests++; if (bus.in_code !== 4'h2) begin fails++; $display("FAIL rst_imem_code got %h exp %h", bus.in_code, 4'h2); end
        tests++; if (bus.ra !== 4'h1) begin fails++; $display("FAIL rst_ra got %h exp %h", bus.ra, 4'h1); end
        tests++; if (bus.val_a !== 64'd0) begin fails++; $display("FAIL rst_reg_zero got %h exp %h", bus.val_a, 64'd0); end
        tests++; if (bus.zf !== 1'b1 || bus.sf !== 1'b0 || bus.of !== 1'b0) begin fails++; $display("FAIL rst_cc got %b%b%b exp 100", bus.zf, bus.sf, bus.of); end
        tests++; if (bus.cnd !== 1'b1) begin fails++; $display("FAIL rst_rrmov_cnd got %b exp 1", bus.cnd); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_irmovq;
        bus.p_ctr = 64'd0;
        #1;
        tests++; if (bus.in_code !== 4'h3 || bus.in_fun !== 4'h0) begin fails++; $display("FAIL irm_code got %h%h exp 30", bus.in_code, bus.in_fun); end
        tests++; if (bus.ra !== 4'hF || bus.rb !== 4'h2) begin fails++; $display("FAIL irm_regs got %h%h exp F2", bus.ra, bus.rb); end
        tests++; if (bus.val_c !== 64'd10) begin fails++; $display("FAIL irm_val_c got %h exp %h", bus.val_c, 64'd10); end
        tests++; if (bus.val_e !== 64'd10) begin fails++; $display("FAIL irm_val_e got %h exp %h", bus.val_e, 64'd10); end
        tests++; if (bus.val_p !== 64'd10) begin fails++; $display("FAIL irm_val_p got %h exp %h", bus.val_p, 64'd10); end
        tests++; if (bus.bad_mem !== 1'b0 || bus.in_error !== 1'b0 || bus.cnd !== 1'b0) begin fails++; $display("FAIL irm_status got bm%b err%b cnd%b exp 000", bus.bad_mem, bus.in_error, bus.cnd); end
    endtask

    task automatic test_regwrite;
        set_regs(4'd2, 64'd10, 4'd3, 64'd3);
        set_regs(4'd5, 64'hAAAA, 4'd5, 64'hBBBB);
        load(64'd40, 2, {16'h205F, 64'h0});
        bus.p_ctr = 64'd40;
        #1;
        tests++; if (bus.val_a !== 64'hBBBB) begin fails++; $display("FAIL wb_m_wins got %h exp %h", bus.val_a, 64'hBBBB); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_subq;
        load(64'd20, 2, {16'h6123, 64'h0});
        bus.p_ctr = 64'd20;
        #1;
        tests++; if (bus.val_a !== 64'd10 || bus.val_b !== 64'd3) begin fails++; $display("FAIL sub_ops got %h %h exp a %h b %h", bus.val_a, bus.val_b, 64'd10, 64'd3); end
        tests++; if (bus.val_e !== 64'hFFFF_FFFF_FFFF_FFF9) begin fails++; $display("FAIL sub_val_e got %h exp %h", bus.val_e, 64'hFFFF_FFFF_FFFF_FFF9); end
        tests++; if (bus.zf !== 1'b1) begin fails++; $display("FAIL sub_cc_pre got zf %b exp 1", bus.zf); end
        @(negedge clock);
        tests++; if (bus.zf !== 1'b0 || bus.sf !== 1'b1 || bus.of !== 1'b0) begin fails++; $display("FAIL sub_cc got %b%b%b exp 010", bus.zf, bus.sf, bus.of); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_addq_of;
        set_regs(4'd6, 64'h7FFF_FFFF_FFFF_FFFF, 4'd7, 64'd1);
        load(64'd50, 2, {16'h6076, 64'h0});
        load(64'd60, 9, {72'h74_4000000000000000, 8'h0});
        bus.p_ctr = 64'd50;
        #1;
        tests++; if (bus.val_e !== 64'h8000_0000_0000_0000) begin fails++; $display("FAIL add_val_e got %h exp %h", bus.val_e, 64'h8000_0000_0000_0000); end
        @(negedge clock);
        tests++; if (bus.zf !== 1'b0 || bus.sf !== 1'b1 || bus.of !== 1'b1) begin fails++; $display("FAIL add_cc got %b%b%b exp 011", bus.zf, bus.sf, bus.of); end
        bus.p_ctr = 64'd60;
        #1;
        tests++; if (bus.in_fun !== 4'h4 || bus.cnd !== 1'b1) begin fails++; $display("FAIL jne_cnd got fun %h cnd %b exp 4 1", bus.in_fun, bus.cnd); end
        tests++; if (bus.val_c !== 64'h40) begin fails++; $display("FAIL jne_val_c got %h exp %h", bus.val_c, 64'h40); end
        tests++; if (bus.val_p !== 64'd69) begin fails++; $display("FAIL jne_val_p got %h exp %h", bus.val_p, 64'd69); end
        load(64'd60, 1, {8'h72, 72'h0});
        #1;
        tests++; if (bus.cnd !== 1'b0) begin fails++; $display("FAIL jl_cnd got %b exp 0", bus.cnd); end
        load(64'd60, 1, {8'h76, 72'h0});
        #1;
        tests++; if (bus.cnd !== 1'b1) begin fails++; $display("FAIL jg_cnd got %b exp 1", bus.cnd); end
        load(64'd60, 1, {8'h71, 72'h0});
        #1;
        tests++; if (bus.cnd !== 1'b0) begin fails++; $display("FAIL jle_cnd got %b exp 0", bus.cnd); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_push_ret;
        set_regs(4'd4, 64'h100, 4'd1, 64'h1234);
        load(64'd70, 3, {24'hA01F90, 56'h0});
        bus.p_ctr = 64'd70;
        #1;
        tests++; if (bus.val_a !== 64'h1234 || bus.val_b !== 64'h100) begin fails++; $display("FAIL push_ops got %h %h exp a %h b %h", bus.val_a, bus.val_b, 64'h1234, 64'h100); end
        tests++; if (bus.val_e !== 64'hF8) begin fails++; $display("FAIL push_val_e got %h exp %h", bus.val_e, 64'hF8); end
        tests++; if (bus.val_p !== 64'd72) begin fails++; $display("FAIL push_val_p got %h exp %h", bus.val_p, 64'd72); end
        bus.p_ctr = 64'd72;
        #1;
        tests++; if (bus.val_e !== 64'h108) begin fails++; $display("FAIL ret_val_e got %h exp %h", bus.val_e, 64'h108); end
        tests++; if (bus.val_a !== 64'h100 || bus.ra !== 4'hF) begin fails++; $display("FAIL ret_src got a %h ra %h exp %h F", bus.val_a, bus.ra, 64'h100); end
        tests++; if (bus.val_p !== 64'd73) begin fails++; $display("FAIL ret_val_p got %h exp %h", bus.val_p, 64'd73); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_errors;
        load(64'd80, 4, {32'hC0006523, 48'h0});
        bus.p_ctr = 64'd80;
        #1;
        tests++; if (bus.in_error !== 1'b1) begin fails++; $display("FAIL err_icode got %b exp 1", bus.in_error); end
        bus.p_ctr = 64'd81;
        #1;
        tests++; if (bus.flag_halt !== 1'b1 || bus.in_error !== 1'b0) begin fails++; $display("FAIL halt got halt %b err %b exp 1 0", bus.flag_halt, bus.in_error); end
        tests++; if (bus.val_p !== 64'd82) begin fails++; $display("FAIL halt_val_p got %h exp %h", bus.val_p, 64'd82); end
        @(negedge clock);
        bus.p_ctr = 64'd82;
        #1;
        tests++; if (bus.in_error !== 1'b1) begin fails++; $display("FAIL err_opq_fun got %b exp 1", bus.in_error); end
        @(negedge clock);
        tests++; if (bus.zf !== 1'b0 || bus.sf !== 1'b1 || bus.of !== 1'b1) begin fails++; $display("FAIL err_cc_hold got %b%b%b exp 011", bus.zf, bus.sf, bus.of); end
        bus.p_ctr = 64'd0;
        load(64'd1020, 1, {8'h30, 72'h0});
        load(64'd1014, 1, {8'h30, 72'h0});
        load(64'd1023, 1, {8'h00, 72'h0});
        load(64'd1024, 1, {8'h60, 72'h0});
        bus.p_ctr = 64'd1020;
        #1;
        tests++; if (bus.bad_mem !== 1'b1 || bus.flag_halt !== 1'b0) begin fails++; $display("FAIL bad_mem_1020 got bm %b halt %b exp 1 0", bus.bad_mem, bus.flag_halt); end
        bus.p_ctr = 64'd1014;
        #1;
        tests++; if (bus.bad_mem !== 1'b0) begin fails++; $display("FAIL bad_mem_1014 got %b exp 0", bus.bad_mem); end
        bus.p_ctr = 64'd1023;
        #1;
        tests++; if (bus.bad_mem !== 1'b0 || bus.flag_halt !== 1'b1) begin fails++; $display("FAIL halt_1023 got bm %b halt %b exp 0 1", bus.bad_mem, bus.flag_halt); end
        bus.p_ctr = 64'd1024;
        #1;
        tests++; if (bus.bad_mem !== 1'b1 || bus.flag_halt !== 1'b0) begin fails++; $display("FAIL bad_mem_1024 got bm %b halt %b exp 1 0", bus.bad_mem, bus.flag_halt); end
        bus.p_ctr = 64'd0;
        #1;
        tests++; if (bus.in_code !== 4'h3) begin fails++; $display("FAIL oob_write_ignored got %h exp 3", bus.in_code); end
    endtask

    task automatic test_no_bypass;
        load(64'd90, 2, {16'h208F, 64'h0});
        bus.p_ctr = 64'd90;
        @(negedge clock);
        bus.wb_dst_e = 4'd8; bus.wb_val_e = 64'h55;
        #1;
        tests++; if (bus.val_a !== 64'd0) begin fails++; $display("FAIL no_bypass got %h exp %h", bus.val_a, 64'd0); end
        @(negedge clock);
        bus.wb_dst_e = 4'hF;
        #1;
        tests++; if (bus.val_a !== 64'h55) begin fails++; $display("FAIL wb_after_edge got %h exp %h", bus.val_a, 64'h55); end
        bus.p_ctr = 64'd0;
    endtask

    task automatic test_reset_mid;
        load(64'd92, 2, {16'h202F, 64'h0});
        bus.p_ctr = 64'd92;
        #1;
        tests++; if (bus.val_a !== 64'd10) begin fails++; $display("FAIL mid_pre_r2 got %h exp %h", bus.val_a, 64'd10); end
        @(negedge clock);
        reset = 1'b1;
        bus.wb_dst_e = 4'd2; bus.wb_val_e = 64'h99;
        @(negedge clock);
        reset = 1'b0;
        bus.wb_dst_e = 4'hF;
        #1;
        tests++; if (bus.val_a !== 64'd0) begin fails++; $display("FAIL mid_r2_cleared got %h exp %h", bus.val_a, 64'd0); end
        tests++; if (bus.zf !== 1'b1 || bus.sf !== 1'b0 || bus.of !== 1'b0) begin fails++; $display("FAIL mid_cc got %b%b%b exp 100", bus.zf, bus.sf, bus.of); end
        bus.p_ctr = 64'd0;
        #1;
        tests++; if (bus.in_code !== 4'h3 || bus.val_c !== 64'd10) begin fails++; $display("FAIL mid_imem_kept got %h %h exp 3 %h", bus.in_code, bus.val_c, 64'd10); end
        bus.p_ctr = 64'd40;
        #1;
        tests++; if (bus.val_a !== 64'd0) begin fails++; $display("FAIL mid_r5_cleared got %h exp %h", bus.val_a, 64'd0); end
        bus.p_ctr = 64'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.p_ctr      = 64'd0;
        bus.imem_we    = 1'b0;
        bus.imem_waddr = 64'd0;
        bus.imem_wdata = 8'h00;
        bus.wb_dst_e   = 4'hF;
        bus.wb_val_e   = 64'd0;
        bus.wb_dst_m   = 4'hF;
        bus.wb_val_m   = 64'd0;

        test_reset;
        test_irmovq;
        test_regwrite;
        test_subq;
        test_addq_of;
        test_push_ret;
        test_errors;
        test_no_bypass;
        test_reset_mid;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
